// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter FSM states and burst helpers.
// Imported by the round-robin arbiter and its priority picker.
package ahb_pkg;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_WRAP4  = 3'd2;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_WRAP16 = 3'd6;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    PARK,
    OWN,
    BURST,
    LOCKED
  } arb_state_e;

  // Zero marks the undefined-length INCR burst.
  function automatic logic [4:0] burst_len(
    input logic [2:0] hburst
  );
    logic [4:0] len;
    case (hburst)
      HB_SINGLE: len = 5'd1;
      HB_INCR:   len = 5'd0;
      HB_WRAP4,
      HB_INCR4:  len = 5'd4;
      HB_WRAP8,
      HB_INCR8:  len = 5'd8;
      default:   len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after last,
// searching last+1, last+2, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Walk from the farthest slot inward so the nearest wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with burst-boundary tracking,
// locked-sequence hold and default-master parking.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER_D,
  output logic                           HMASTLOCK
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF   = IW'(DEFAULT_MASTER);
  localparam logic [IW-1:0] LAST0 = IW'(NUM_MASTERS - 1);

  arb_state_e             st_q, st_d;
  logic [4:0]             beats_q, beats_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          hm_q, hm_d;
  logic [IW-1:0]          hmd_q, hmd_d;
  logic [IW-1:0]          last_q, last_d;
  logic                   lock_q, lock_d;

  logic [4:0]    len;
  logic          pv;
  logic [IW-1:0] pidx;
  logic          own_lock;
  logic          point;
  logic          rearb;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req   (HBUSREQ),
    .last  (last_q),
    .valid (pv),
    .idx   (pidx)
  );

  assign len      = burst_len(HBURST);
  assign own_lock = HLOCK[gidx_q];
  assign rearb    = HREADY && !own_lock && point;

  // NONSEQ inside a running fixed burst is an early termination.
  always_comb begin
    point = 1'b0;
    unique case (HTRANS)
      TR_IDLE:   point = 1'b1;
      TR_NONSEQ: point = (len <= 5'd1) ||
                         (beats_q != '0);
      TR_SEQ:    point = (HBURST == HB_INCR) ||
                         (beats_q == 5'd2);
      default:   point = 1'b0;
    endcase
  end

  always_comb begin
    beats_d = beats_q;
    if (HREADY) begin
      unique case (HTRANS)
        TR_IDLE:   beats_d = '0;
        TR_NONSEQ: beats_d = (len > 5'd1) ?
                             len - 5'd1 : '0;
        TR_SEQ:    beats_d = (beats_q != '0) ?
                             beats_q - 5'd1 : '0;
        default:   beats_d = beats_q;
      endcase
    end
  end

  always_comb begin
    st_d   = st_q;
    gidx_d = gidx_q;
    hm_d   = hm_q;
    hmd_d  = hmd_q;
    lock_d = lock_q;
    last_d = last_q;
    if (HREADY) begin
      hm_d   = gidx_q;
      hmd_d  = hm_q;
      lock_d = own_lock;
      if (gidx_q != hm_q) last_d = gidx_q;
      if (rearb) gidx_d = pv ? pidx : DEF;
      if (own_lock)           st_d = LOCKED;
      else if (rearb && !pv)  st_d = PARK;
      else if (beats_d != '0) st_d = BURST;
      else if (rearb || st_q != PARK)
        st_d = OWN;
    end
  end

  always_comb begin
    gnt_d         = '0;
    gnt_d[gidx_d] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q    <= PARK;
      beats_q <= '0;
      gnt_q   <= '0;
      gnt_q[DEF] <= 1'b1;
      gidx_q  <= DEF;
      hm_q    <= DEF;
      hmd_q   <= DEF;
      last_q  <= LAST0;
      lock_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      hm_q    <= hm_d;
      hmd_q   <= hmd_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
    end
  end

  assign HGRANT    = gnt_q;
  assign HMASTER   = hm_q;
  assign HMASTER_D = hmd_q;
  assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: directed steps queue
// expected outputs, a monitor pops and compares after each edge.
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  localparam int DC = -1;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] HBUSREQ = '0;
  logic [3:0] HLOCK = '0;
  logic [1:0] HTRANS = TR_IDLE;
  logic [2:0] HBURST = HB_SINGLE;
  logic       HREADY = 1'b1;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;

  typedef struct {
    string nm;
    int g, hm, hmd, ml, bl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  ahb_rr_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic void cmp(input string nm,
                              input string f,
                              input logic [31:0] act,
                              input int ex);
    if (ex < 0) return;
    n_vec++;
    if (act !== 32'(ex)) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d",
               nm, f, act, ex);
    end
  endfunction

  function automatic void push(input string nm,
                               input int g, hm, hmd,
                               input int ml, bl);
    exp_t e;
    e.nm = nm; e.g = g; e.hm = hm;
    e.hmd = hmd; e.ml = ml; e.bl = bl;
    sb.push_back(e);
  endfunction

  task automatic step(input logic [3:0] rq, lk,
                      input logic [1:0] tr,
                      input logic [2:0] bu,
                      input logic rdy,
                      input int g, hm, hmd, ml, bl,
                      input string nm);
    @(negedge HCLK);
    HBUSREQ = rq; HLOCK = lk;
    HTRANS = tr; HBURST = bu; HREADY = rdy;
    push(nm, g, hm, hmd, ml, bl);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge HCLK or negedge HRESETn);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.nm, "HGRANT", 32'(HGRANT), e.g);
        cmp(e.nm, "HMASTER", 32'(HMASTER), e.hm);
        cmp(e.nm, "HMASTER_D", 32'(HMASTER_D), e.hmd);
        cmp(e.nm, "HMASTLOCK", 32'(HMASTLOCK), e.ml);
        cmp(e.nm, "beats_left", 32'(dut.beats_q), e.bl);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 0, 0, 0, "rst0");
    step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 0, 0, 0, "rst1");
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++)
      step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 0, 0, 0, "park");

    step(4'h4, 4'h0, TR_IDLE, HB_SINGLE, 1, 4, 0, 0, 0, 0, "m2_gnt");
    step(4'h4, 4'h0, TR_IDLE, HB_SINGLE, 1, 4, 2, 0, 0, 0, "m2_hm");
    step(4'h4, 4'h0, TR_IDLE, HB_SINGLE, 1, 4, 2, 2, 0, 0, "m2_hmd");

    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 2, 2, 0, 0, "m1_gnt");
    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 1, 2, 0, 0, "m1_hm");
    step(4'hA, 4'h0, TR_NONSEQ, HB_INCR4, 1, 2, 1, 1, 0, 3, "i4_a0");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 2, 1, 1, 0, 2, "i4_a1");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 8, 1, 1, 0, 1, "i4_a2");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 8, 3, 1, 0, 0, "i4_a3");
    step(4'h8, 4'h0, TR_IDLE, HB_SINGLE, 1, 8, 3, 3, 0, 0, "i4_end");

    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 3, 3, 0, 0, "w_gnt");
    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 1, 3, 0, 0, "w_hm");
    step(4'hA, 4'h0, TR_NONSEQ, HB_INCR4, 1, 2, 1, 1, 0, 3, "w_a0");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 2, 1, 1, 0, 2, "w_a1");
    for (int i = 0; i < 3; i++)
      step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 0, 2, 1, 1, 0, 2, "w_wait");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 8, 1, 1, 0, 1, "w_a2");
    step(4'hA, 4'h0, TR_SEQ, HB_INCR4, 1, 8, 3, 1, 0, 0, "w_a3");
    step(4'h8, 4'h0, TR_IDLE, HB_SINGLE, 1, 8, 3, 3, 0, 0, "w_end");

    step(4'h1, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 3, 3, 0, 0, "m0_gnt");
    step(4'h1, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 3, 0, 0, "m0_hm");
    step(4'h7, 4'h1, TR_NONSEQ, HB_SINGLE, 1, 1, 0, 0, 1, 0, "lk_s0");
    step(4'h7, 4'h1, TR_NONSEQ, HB_SINGLE, 1, 1, 0, 0, 1, 0, "lk_s1");
    step(4'h6, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 0, 0, 0, 0, "ul_m1");
    step(4'h6, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 1, 0, 0, 0, "ul_hm1");
    step(4'h6, 4'h0, TR_IDLE, HB_SINGLE, 1, 4, 1, 1, 0, 0, "ul_m2");
    step(4'h4, 4'h0, TR_IDLE, HB_SINGLE, 1, 4, 2, 1, 0, 0, "ul_hm2");

    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 2, 2, 0, 0, "r_gnt");
    step(4'h2, 4'h0, TR_IDLE, HB_SINGLE, 1, 2, 1, 2, 0, 0, "r_hm");
    step(4'h2, 4'h0, TR_NONSEQ, HB_INCR8, 1, 2, 1, 1, 0, 7, "i8_a0");
    step(4'h2, 4'h0, TR_SEQ, HB_INCR8, 1, 2, 1, 1, 0, 6, "i8_a1");
    step(4'h2, 4'h0, TR_SEQ, HB_INCR8, 1, 2, 1, 1, 0, 5, "i8_a2");
    step(4'h2, 4'h0, TR_SEQ, HB_INCR8, 1, 2, 1, 1, 0, 4, "i8_a3");
    step(4'h2, 4'h0, TR_SEQ, HB_INCR8, 1, 2, 1, 1, 0, 3, "i8_a4");
    @(negedge HCLK);
    #2;
    push("async_rst", 1, 0, 0, 0, 0);
    HRESETn = 1'b0;
    step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 0, 0, 0, "rst_hold");
    @(negedge HCLK);
    HRESETn = 1'b1;

    step(4'h1, 4'h0, TR_NONSEQ, HB_INCR8, 1, 1, 0, 0, 0, 7, "pr_a0");
    step(4'h1, 4'h0, TR_SEQ, HB_INCR8, 1, 1, 0, 0, 0, 6, "pr_a1");
    step(4'h8, 4'h0, TR_NONSEQ, HB_INCR4, 1, 8, 0, 0, 0, 3, "early");
    step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 3, 0, 0, 0, "pk_gnt");
    step(4'h0, 4'h0, TR_IDLE, HB_SINGLE, 1, 1, 0, 3, 0, 0, "pk_hm");

    repeat (3) @(negedge HCLK);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin AHB arbiter for the bridged bus segment. It drives the per-master HGRANT lines that the transceiver control block uses to open the master address and data paths. It tracks burst beats so that ownership changes only at legal AHB boundaries. It honours locked sequences and parks the bus on a default master when no one requests it.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16)
- DEFAULT_MASTER, 0, master index granted when no requests are pending (park master)

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset; asynchronous, active-low
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request
- HTRANS  in  2  transfer type from the current address-phase owner
- HBURST  in  3  burst type from the current address-phase owner
- HREADY  in  1  bus-wide transfer-complete
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  $clog2(NUM_MASTERS)  index of the address-phase owner, registered
- HMASTER_D  out  $clog2(NUM_MASTERS)  index of the data-phase owner, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER).
  - HMASTER = HMASTER_D = DEFAULT_MASTER.
  - HMASTLOCK = 0, beats_left = 0, state = PARK, last_owner = NUM_MASTERS-1.
- FSM states:
  - **PARK**: default grant, no request.
  - **OWN**: single transfer or undefined-length INCR.
  - **BURST**: fixed-length burst in progress.
  - **LOCKED**: owner holds HLOCK.
- Burst beat counter (beats_left, 5 bits):
  - Loads L-1 on HREADY & NONSEQ with HBURST in {INCR4/WRAP4 (L=4), INCR8/WRAP8 (L=8), INCR16/WRAP16 (L=16)}.
  - Decrements on HREADY & SEQ.
  - Holds on BUSY or on HREADY=0.
  - Cleared on HREADY & (IDLE, or NONSEQ with SINGLE/INCR).
- Rearbitration point (all require HREADY=1 and the owner not locked):
  - HTRANS=IDLE;
  - HTRANS=NONSEQ with HBURST SINGLE or INCR;
  - HTRANS=SEQ with HBURST=INCR;
  - HTRANS=SEQ with beats_left==2, i.e. the second-to-last beat of a fixed burst.
- Winner selection:
  - Search order is last_owner+1, last_owner+2, … mod NUM_MASTERS; the first asserted HBUSREQ wins.
  - No request → DEFAULT_MASTER, and state goes to PARK.
  - The current owner, if still requesting and no other master requests, keeps the grant.
- Locking:
  - If the granted master asserts HLOCK, state goes to LOCKED and the grant is frozen.
  - The grant is released only at a rearbitration point taken after HLOCK of the owner is deasserted.
  - HMASTLOCK <= HLOCK[granted index] on every HREADY edge.
- Early burst termination: if the owner issues IDLE or NONSEQ before beats_left reaches 0, the counter reloads or clears per the counter rules, and that edge is a rearbitration point.
- HREADY=0 freezes HGRANT, HMASTER, HMASTER_D, HMASTLOCK, beats_left and state.
- last_owner updates to the new HMASTER value whenever HMASTER changes.

## Timing
- A request sampled at edge n is granted at edge n at the earliest, if edge n is a rearbitration point. HGRANT is visible in cycle n+1.
- On every HREADY=1 edge:
  - HMASTER <= index(HGRANT), so the new master drives the address one HREADY cycle after its grant.
  - HMASTER_D <= HMASTER, so data-phase ownership lags address-phase ownership by one HREADY-qualified cycle.
- INCR4 timeline (address beats A0 NONSEQ, A1–A3 SEQ, no waits):
  - HGRANT changes at the edge completing A2.
  - HMASTER changes at the edge completing A3.
  - HMASTER_D changes one edge later.
- Simultaneous requests from all masters with last_owner=1: the grant order is 2,3,0,1.
- Reset asserted mid-burst: all outputs take their reset values asynchronously; beats_left is discarded.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HBURST encodings: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - Function burst_len(HBURST) returning 1/4/8/16, or 0 for INCR.
  - FSM state enum.
- Sub-module rr_pick: purely combinational rotate-priority encoder.
  - Inputs: request vector and last_owner.
  - Outputs: valid and index.
- The top level holds the FSM, beats_left, grant/owner registers and the lock logic.

## Test plan
- Reset, no requests → HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; these hold for 10 cycles.
- M2 requests while parked with IDLE on the bus → HGRANT=4'b0100 the next cycle; HMASTER=2 one cycle later; HMASTER_D=2 one cycle after that.
- M1 runs INCR4 with zero waits while M3 requests → HGRANT moves to M3 at the edge completing A2; HMASTER=3 after A3.
- Same INCR4 with HREADY=0 for 3 cycles on A2 → the grant change is delayed exactly 3 cycles; beats_left holds at 2.
- M0 asserts HLOCK on two SINGLE transfers while M1 and M2 request → M0 keeps the grant and HMASTLOCK=1 throughout; after HLOCK drops and IDLE, the grant goes to M1, then to M2.
- HRESETn pulsed low mid-INCR8 at beat 5 → outputs return to reset values immediately; the first NONSEQ after reset reloads beats_left=7.
